// File: rtl/vfu_result_arbiter.sv
// Round-robin arbiter sharing one lane VRF write port between the vector ALU and the MFPU,
// with a registered output stage. Define VFU_RESULT_ARB_PERF_EN to enable the conflict counter.
module vfu_result_arbiter #(
  parameter  int unsigned AddrWidth = 10,
  parameter  int unsigned DataWidth = 64,
  parameter  int unsigned IdWidth   = 3,
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Vector ALU result (requester 0)
  input  logic                 alu_req_i,
  input  logic [IdWidth-1:0]   alu_id_i,
  input  logic [AddrWidth-1:0] alu_addr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  input  logic [StrbWidth-1:0] alu_be_i,
  output logic                 alu_gnt_o,
  // Multiplier/FPU result (requester 1)
  input  logic                 mfpu_req_i,
  input  logic [IdWidth-1:0]   mfpu_id_i,
  input  logic [AddrWidth-1:0] mfpu_addr_i,
  input  logic [DataWidth-1:0] mfpu_wdata_i,
  input  logic [StrbWidth-1:0] mfpu_be_i,
  output logic                 mfpu_gnt_o,
  // VRF write port
  output logic                 vrf_req_o,
  output logic [IdWidth-1:0]   vrf_id_o,
  output logic [AddrWidth-1:0] vrf_addr_o,
  output logic [DataWidth-1:0] vrf_wdata_o,
  output logic [StrbWidth-1:0] vrf_be_o,
  input  logic                 vrf_gnt_i,
  output logic [15:0]          conflict_cnt_o
);

  typedef enum logic {
    PTR_ALU  = 1'b0,
    PTR_MFPU = 1'b1
  } ptr_e;

  ptr_e                 r_ptr;
  logic                 r_out_valid;
  logic [IdWidth-1:0]   r_id;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic [StrbWidth-1:0] r_be;

  logic w_load_en;
  logic w_both;
  logic w_alu_win;
  logic w_mfpu_win;
  logic w_any_win;

  // The stage can accept a new result when empty or when its current result leaves this cycle.
  assign w_load_en = !r_out_valid || vrf_gnt_i;
  assign w_both    = alu_req_i && mfpu_req_i;
  assign w_any_win = w_alu_win || w_mfpu_win;

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_alu_win  = 1'b0;
    w_mfpu_win = 1'b0;
    if (!rst_i && w_load_en) begin
      if (w_both) begin
        if (r_ptr == PTR_ALU) w_alu_win  = 1'b1;
        else                  w_mfpu_win = 1'b1;
      end else begin
        w_alu_win  = alu_req_i;
        w_mfpu_win = mfpu_req_i;
      end
    end
  end

  assign alu_gnt_o  = w_alu_win;
  assign mfpu_gnt_o = w_mfpu_win;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_ptr       <= PTR_ALU;
      r_id        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
    end else begin
      if (w_load_en) r_out_valid <= w_any_win;
      if (w_alu_win) begin
        r_id    <= alu_id_i;
        r_addr  <= alu_addr_i;
        r_wdata <= alu_wdata_i;
        r_be    <= alu_be_i;
      end else if (w_mfpu_win) begin
        r_id    <= mfpu_id_i;
        r_addr  <= mfpu_addr_i;
        r_wdata <= mfpu_wdata_i;
        r_be    <= mfpu_be_i;
      end
      // Priority passes to the loser only when both competed, so the waiting unit goes next.
      if (w_both && w_any_win) r_ptr <= w_alu_win ? PTR_MFPU : PTR_ALU;
    end
  end

  assign vrf_req_o   = r_out_valid;
  assign vrf_id_o    = r_id;
  assign vrf_addr_o  = r_addr;
  assign vrf_wdata_o = r_wdata;
  assign vrf_be_o    = r_be;

`ifdef VFU_RESULT_ARB_PERF_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_conflict_cnt <= '0;
    end else if (w_both && (w_alu_win ^ w_mfpu_win) && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vfu_result_arbiter.sv
// Directed self-checking bench for vfu_result_arbiter; expectations follow
// VFU_RESULT_ARB_PERF_EN when the macro is defined for the build.
module tb_vfu_result_arbiter;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int IW = 3;
  localparam int SW = DW / 8;

`ifdef VFU_RESULT_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_req, mfpu_req;
  logic [IW-1:0] alu_id, mfpu_id;
  logic [AW-1:0] alu_addr, mfpu_addr;
  logic [DW-1:0] alu_wdata, mfpu_wdata;
  logic [SW-1:0] alu_be, mfpu_be;
  logic          alu_gnt, mfpu_gnt;
  logic          vrf_req, vrf_gnt;
  logic [IW-1:0] vrf_id;
  logic [AW-1:0] vrf_addr;
  logic [DW-1:0] vrf_wdata;
  logic [SW-1:0] vrf_be;
  logic [15:0]   conflict_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vfu_result_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .alu_req_i      (alu_req),
    .alu_id_i       (alu_id),
    .alu_addr_i     (alu_addr),
    .alu_wdata_i    (alu_wdata),
    .alu_be_i       (alu_be),
    .alu_gnt_o      (alu_gnt),
    .mfpu_req_i     (mfpu_req),
    .mfpu_id_i      (mfpu_id),
    .mfpu_addr_i    (mfpu_addr),
    .mfpu_wdata_i   (mfpu_wdata),
    .mfpu_be_i      (mfpu_be),
    .mfpu_gnt_o     (mfpu_gnt),
    .vrf_req_o      (vrf_req),
    .vrf_id_o       (vrf_id),
    .vrf_addr_o     (vrf_addr),
    .vrf_wdata_o    (vrf_wdata),
    .vrf_be_o       (vrf_be),
    .vrf_gnt_i      (vrf_gnt),
    .conflict_cnt_o (conflict_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic req, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    alu_req   = req;
    alu_id    = id;
    alu_addr  = addr;
    alu_wdata = wdata;
    alu_be    = 8'hF0 | SW'(id);
  endtask

  task automatic set_mfpu(input logic req, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    mfpu_req   = req;
    mfpu_id    = id;
    mfpu_addr  = addr;
    mfpu_wdata = wdata;
    mfpu_be    = 8'h0F | SW'({id, 4'h0});
  endtask

  initial begin
    logic       cnt_nonzero;
    logic [9:0] exp_addr;

    rst     = 1'b1;
    vrf_gnt = 1'b0;
    set_alu (1'b1, 3'd0, '0, '0);
    set_mfpu(1'b1, 3'd0, '0, '0);
    tick();
    tick();
    #2;
    check("rst_alu_gnt",  64'(alu_gnt),  64'd0);
    check("rst_mfpu_gnt", 64'(mfpu_gnt), 64'd0);
    check("rst_vrf_req",  64'(vrf_req),  64'd0);
    check("rst_vrf_id",   64'(vrf_id),   64'd0);
    check("rst_vrf_addr", 64'(vrf_addr), 64'd0);
    check("rst_vrf_data", vrf_wdata,     64'd0);
    check("rst_vrf_be",   64'(vrf_be),   64'd0);
    check("rst_cnt",      64'(conflict_cnt), 64'd0);

    // ALU only, VRF always ready
    tick();
    rst = 1'b0;
    set_mfpu(1'b0, 3'd0, '0, '0);
    set_alu (1'b1, 3'd1, 10'h012, 64'hDEAD);
    vrf_gnt = 1'b1;
    #2;
    check("t1_alu_gnt",  64'(alu_gnt),  64'd1);
    check("t1_mfpu_gnt", 64'(mfpu_gnt), 64'd0);
    tick();
    alu_req = 1'b0;
    #2;
    check("t1_vrf_req",  64'(vrf_req),  64'd1);
    check("t1_vrf_addr", 64'(vrf_addr), 64'h012);
    check("t1_vrf_data", vrf_wdata,     64'hDEAD);
    check("t1_vrf_id",   64'(vrf_id),   64'd1);
    check("t1_vrf_be",   64'(vrf_be),   64'hF1);
    tick();
    #2;
    check("t1_drain", 64'(vrf_req), 64'd0);

    // Both request for 6 cycles: strict alternation starting with ALU
    for (int i = 0; i < 6; i++) begin
      tick();
      set_alu (1'b1, 3'd2, 10'(10'h100 + i), 64'(64'hA0 + i));
      set_mfpu(1'b1, 3'd3, 10'(10'h200 + i), 64'(64'hB0 + i));
      #2;
      check($sformatf("t2_alu_gnt%0d", i),  64'(alu_gnt),  64'(i % 2 == 0));
      check($sformatf("t2_mfpu_gnt%0d", i), 64'(mfpu_gnt), 64'(i % 2 == 1));
      if (i > 0) begin
        exp_addr = ((i - 1) % 2 == 0) ? 10'(10'h100 + i - 1) : 10'(10'h200 + i - 1);
        check($sformatf("t2_vrf_addr%0d", i), 64'(vrf_addr), 64'(exp_addr));
      end
    end
    tick();
    alu_req  = 1'b0;
    mfpu_req = 1'b0;
    #2;
    check("t2_last_addr", 64'(vrf_addr),     64'h205);
    check("t2_last_id",   64'(vrf_id),       64'd3);
    check("t2_last_data", vrf_wdata,         64'hB5);
    check("t2_cnt",       64'(conflict_cnt), PERF ? 64'd6 : 64'd0);

    // Backpressure with output full and MFPU waiting
    tick();
    set_alu(1'b1, 3'd4, 10'h055, 64'h1111);
    vrf_gnt = 1'b0;
    #2;
    check("t3_fill_gnt", 64'(alu_gnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      alu_req = 1'b0;
      set_mfpu(1'b1, 3'd6, 10'h0AA, 64'h2222);
      #2;
      check($sformatf("t3_hold_gnt%0d", i),  64'(mfpu_gnt), 64'd0);
      check($sformatf("t3_hold_req%0d", i),  64'(vrf_req),  64'd1);
      check($sformatf("t3_hold_id%0d", i),   64'(vrf_id),   64'd4);
      check($sformatf("t3_hold_addr%0d", i), 64'(vrf_addr), 64'h055);
      check($sformatf("t3_hold_data%0d", i), vrf_wdata,     64'h1111);
    end
    tick();
    vrf_gnt = 1'b1;
    #2;
    check("t3_rel_gnt", 64'(mfpu_gnt), 64'd1);
    check("t3_rel_id",  64'(vrf_id),   64'd4);
    tick();
    mfpu_req = 1'b0;
    #2;
    check("t3_next_req",  64'(vrf_req),  64'd1);
    check("t3_next_id",   64'(vrf_id),   64'd6);
    check("t3_next_addr", 64'(vrf_addr), 64'h0AA);
    check("t3_next_data", vrf_wdata,     64'h2222);
    tick();
    #2;
    check("t3_drain", 64'(vrf_req), 64'd0);

    // Reset mid-operation: ALU wins a conflict first, leaving the pointer on MFPU
    tick();
    set_alu (1'b1, 3'd5, 10'h0C3, 64'h5555);
    set_mfpu(1'b1, 3'd7, 10'h33C, 64'h7777);
    #2;
    check("t4_pre_alu_gnt", 64'(alu_gnt), 64'd1);
    tick();
    vrf_gnt = 1'b0;
    #2;
    check("t4_full_id",   64'(vrf_id),   64'd5);
    check("t4_full_gnta", 64'(alu_gnt),  64'd0);
    check("t4_full_gntm", 64'(mfpu_gnt), 64'd0);
    tick();
    rst = 1'b1;
    #2;
    check("t4_rst_alu_gnt",  64'(alu_gnt),  64'd0);
    check("t4_rst_mfpu_gnt", 64'(mfpu_gnt), 64'd0);
    tick();
    rst     = 1'b0;
    vrf_gnt = 1'b1;
    #2;
    check("t4_post_req",      64'(vrf_req),      64'd0);
    check("t4_post_id",       64'(vrf_id),       64'd0);
    check("t4_post_cnt",      64'(conflict_cnt), 64'd0);
    check("t4_post_alu_gnt",  64'(alu_gnt),      64'd1);
    check("t4_post_mfpu_gnt", 64'(mfpu_gnt),     64'd0);
    tick();
    alu_req  = 1'b0;
    mfpu_req = 1'b0;
    #2;
    check("t4_out_req", 64'(vrf_req),      64'd1);
    check("t4_out_id",  64'(vrf_id),       64'd5);
    check("t4_out_cnt", 64'(conflict_cnt), PERF ? 64'd1 : 64'd0);

    // Counter saturation: 65540 further conflict cycles
    cnt_nonzero = 1'b0;
    tick();
    alu_req  = 1'b1;
    mfpu_req = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      #2;
      if (conflict_cnt != 16'd0) cnt_nonzero = 1'b1;
      tick();
    end
    alu_req  = 1'b0;
    mfpu_req = 1'b0;
    #2;
    check("t5_cnt_final",   64'(conflict_cnt), PERF ? 64'hFFFF : 64'd0);
    check("t5_cnt_nonzero", 64'(cnt_nonzero),  PERF ? 64'd1 : 64'd0);
    tick();
    #2;
    check("t5_cnt_held", 64'(conflict_cnt), PERF ? 64'hFFFF : 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
